// File: rtl/tdm_pkg.sv
// Shared types and slot-length helper for the TDM demultiplexer.
// Build option: TDM_DEMUX_PARITY_EN appends an even-parity bit to every slot.
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Bits per slot on the wire: data bits plus the optional parity bit.
  function automatic int unsigned slot_len(input int unsigned w);
    return PAR_EN ? w + 1 : w;
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Serial TDM input and demultiplexed frame output bundle.
interface tdm_demux_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  logic                   din;
  logic                   din_vld;
  logic                   fsync;
  logic [N*W-1:0]         dout;
  logic                   dout_vld;
  logic [$clog2(N)-1:0]   ch_o;
  logic                   locked;
  logic                   sync_err;
  logic [N-1:0]           par_err;

  modport master (
    output din, din_vld, fsync,
    input  dout, dout_vld, ch_o, locked, sync_err, par_err
  );

  modport slave (
    input  din, din_vld, fsync,
    output dout, dout_vld, ch_o, locked, sync_err, par_err
  );
endinterface

// File: rtl/tdm_slot_sipo.sv
// Slot deserializer: shift register, bit counter, slot-done strobe, parity check.
// With TDM_DEMUX_PARITY_EN the last bit of a slot is its even-parity bit.
module tdm_slot_sipo
  import tdm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         start,
  input  logic         abort,
  input  logic         din,
  output logic         first_c,
  output logic         done_c,
  output logic [W-1:0] data_c,
  output logic         perr_c
);

  localparam int unsigned S   = slot_len(W);
  localparam int unsigned CW  = $clog2(S);
  // The final data bit arrives live on din when there is no parity bit.
  localparam int unsigned SRW = PAR_EN ? W : W - 1;

  logic [CW-1:0]  cnt;
  logic [SRW-1:0] sr;

  assign first_c = (cnt == '0);
  assign done_c  = shift && (cnt == CW'(S - 1));

`ifdef TDM_DEMUX_PARITY_EN
  assign data_c = sr;
  assign perr_c = ^{sr, din};
`else
  assign data_c = {sr, din};
  assign perr_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(1);
      sr  <= SRW'(din);
    end else if (shift) begin
      cnt <= done_c ? '0 : cnt + CW'(1);
      sr  <= SRW'({sr, din});
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: framing FSM, channel counter and frame buffers.
// Build option: TDM_DEMUX_PARITY_EN enables per-slot parity and par_err.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic        clk,
  input logic        rst,
  tdm_demux_if.slave bus
);

  localparam int unsigned CHW = $clog2(N);
  localparam int unsigned FW  = N * W;

  tdm_state_e     state, state_nxt;
  logic [CHW-1:0] ch_q;
  logic [FW-1:0]  work_q, dout_q, frame_nxt_c;
  logic           dout_vld_q, sync_err_q;
  logic           sh_c, start_c, abort_c, serr_c;
  logic           first_c, done_c, perr_c;
  logic [W-1:0]   data_c;
  logic           frame_first_c, last_ch_c;

  tdm_slot_sipo #(.W(W)) u_sipo (
    .clk     (clk),
    .rst     (rst),
    .shift   (sh_c),
    .start   (start_c),
    .abort   (abort_c),
    .din     (bus.din),
    .first_c (first_c),
    .done_c  (done_c),
    .data_c  (data_c),
    .perr_c  (perr_c)
  );

  assign frame_first_c = first_c && (ch_q == '0);
  assign last_ch_c     = (ch_q == CHW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // A mid-frame fsync restarts the frame; a missing fsync on bit 0 drops lock.
  always_comb begin
    state_nxt = state;
    sh_c      = 1'b0;
    start_c   = 1'b0;
    abort_c   = 1'b0;
    serr_c    = 1'b0;
    case (state)
      HUNT: begin
        if (bus.din_vld && bus.fsync) begin
          start_c   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.din_vld) begin
          if (bus.fsync && !frame_first_c) begin
            serr_c  = 1'b1;
            start_c = 1'b1;
          end else if (!bus.fsync && frame_first_c) begin
            serr_c    = 1'b1;
            abort_c   = 1'b1;
            state_nxt = HUNT;
          end else begin
            sh_c = 1'b1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    frame_nxt_c = work_q;
    frame_nxt_c[32'(ch_q) * W +: W] = data_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      work_q     <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      sync_err_q <= serr_c;
      if (start_c) begin
        ch_q   <= '0;
        work_q <= '0;
      end else if (done_c) begin
        work_q <= frame_nxt_c;
        ch_q   <= last_ch_c ? '0 : ch_q + CHW'(1);
        if (last_ch_c) begin
          dout_q     <= frame_nxt_c;
          dout_vld_q <= 1'b1;
        end
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic [N-1:0] wpar_q, par_q, par_nxt_c;

  always_comb begin
    par_nxt_c       = wpar_q;
    par_nxt_c[ch_q] = perr_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wpar_q <= '0;
      par_q  <= '0;
    end else if (start_c) begin
      wpar_q <= '0;
    end else if (done_c) begin
      wpar_q <= par_nxt_c;
      if (last_ch_c) par_q <= par_nxt_c;
    end
  end

  assign bus.par_err = par_q;
`else
  logic unused_perr;
  assign unused_perr = perr_c;
  assign bus.par_err = '0;
`endif

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.ch_o     = ch_q;
  assign bus.locked   = (state == RUN);
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux against a frame-position reference model.
// Honours TDM_DEMUX_PARITY_EN so the same bench covers both builds.
module tb_tdm_demux;
  import tdm_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned CHW = $clog2(N);
  localparam int unsigned S   = slot_len(W);
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demux_if #(.N(N), .W(W)) bus ();
  tdm_demux #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt = 0;
  int serr_cnt = 0;
  logic [N*W-1:0] got_q[$];

  always @(negedge clk) begin
    if (bus.dout_vld === 1'b1) begin
      vld_cnt++;
      got_q.push_back(bus.dout);
    end
    if (bus.sync_err === 1'b1) serr_cnt++;
  end

  // Reference model: one position counter across the whole frame.
  bit             m_run;
  int             m_pos;
  int             m_serr = 0;
  logic [N*W-1:0] m_frame, m_dout;
  logic [N-1:0]   m_par, m_perr;
  logic [N*W-1:0] exp_q[$];

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_frame = '0; m_par = '0; m_dout = '0; m_perr = '0;
  endtask

  task automatic model_bit(input logic b, input logic fs);
    int k, i;
    if (!m_run) begin
      if (!fs) return;
      m_run = 1; m_pos = 0;
    end else if (m_pos == 0 && !fs) begin
      m_serr++; m_run = 0;
      return;
    end else if (m_pos != 0 && fs) begin
      m_serr++; m_pos = 0; m_frame = '0; m_par = '0;
    end
    k = m_pos / S;
    i = m_pos % S;
    if (i < W) m_frame[k*W + W - 1 - i] = b;
    else       m_par[k] = (^m_frame[k*W +: W]) ^ b;
    m_pos++;
    if (m_pos == N * S) begin
      m_pos = 0; m_dout = m_frame; m_perr = m_par;
      exp_q.push_back(m_frame);
    end
  endtask

  function automatic logic [CHW-1:0] exp_ch();
    return m_run ? CHW'(m_pos / S) : '0;
  endfunction

  // Serial stimulus queues.
  logic bq[$];
  logic fq[$];

  task automatic build_frame(input logic [N*W-1:0] fr, input bit fs, input logic [N-1:0] flip);
    for (int k = 0; k < N; k++) begin
      for (int i = W - 1; i >= 0; i--) begin
        bq.push_back(fr[k*W + i]);
        fq.push_back(fs && k == 0 && i == W - 1);
      end
      if (PAR) begin
        bq.push_back((^fr[k*W +: W]) ^ flip[k]);
        fq.push_back(1'b0);
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.din_vld = 1'b0;
    bus.din     = 1'($urandom);
    bus.fsync   = 1'($urandom);
  endtask

  task automatic send_q(input int gap_pct);
    while (bq.size() > 0) begin
      for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) idle_cycle();
      @(negedge clk);
      bus.din = bq[0]; bus.fsync = fq[0]; bus.din_vld = 1'b1;
      model_bit(bq[0], fq[0]);
      void'(bq.pop_front()); void'(fq.pop_front());
    end
  endtask

  task automatic settle();
    repeat (3) idle_cycle();
    #1;
  endtask

  function automatic logic [N*W-1:0] rand_frame();
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = W'($urandom);
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.din = 1'b1; bus.din_vld = 1'b1; bus.fsync = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %h exp 0", bus.dout); end
    n_cmp++; if (bus.dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_dout_vld: got %b exp 0", bus.dout_vld); end
    n_cmp++; if (bus.ch_o !== '0) begin n_bad++; $display("FAIL reset_ch_o: got %0d exp 0", bus.ch_o); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b exp 0", bus.locked); end
    n_cmp++; if (bus.sync_err !== 1'b0) begin n_bad++; $display("FAIL reset_sync_err: got %b exp 0", bus.sync_err); end
    n_cmp++; if (bus.par_err !== '0) begin n_bad++; $display("FAIL reset_par_err: got %b exp 0", bus.par_err); end
    @(negedge clk);
    rst = 1'b0; bus.din_vld = 1'b0; bus.fsync = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int v0 = vld_cnt, s0 = serr_cnt;
    build_frame(32'hD4C3B2A1, 1'b1, '0);
    send_q(0);
    settle();
    n_cmp++; if (bus.dout !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL basic_dout: got %h exp d4c3b2a1", bus.dout); end
    n_cmp++; if (bus.dout !== m_dout) begin n_bad++; $display("FAIL basic_model: got %h exp %h", bus.dout, m_dout); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL basic_vld_pulses: got %0d exp 1", vld_cnt - v0); end
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL basic_locked: got %b exp 1", bus.locked); end
    n_cmp++; if (serr_cnt - s0 !== 0) begin n_bad++; $display("FAIL basic_sync_err: got %0d exp 0", serr_cnt - s0); end
    n_cmp++; if (bus.par_err !== '0) begin n_bad++; $display("FAIL basic_par_err: got %b exp 0", bus.par_err); end
  endtask

  task automatic test_gaps();
    int v0 = vld_cnt, s0 = serr_cnt;
    build_frame(32'hD4C3B2A1, 1'b1, '0);
    while (bq.size() > 0) begin
      for (int g = 0; g < 8 && $urandom_range(99) < 30; g++) idle_cycle();
      @(negedge clk);
      n_cmp++;
      if (bus.ch_o !== exp_ch()) begin n_bad++; $display("FAIL gaps_ch_o: got %0d exp %0d", bus.ch_o, exp_ch()); end
      bus.din = bq[0]; bus.fsync = fq[0]; bus.din_vld = 1'b1;
      model_bit(bq[0], fq[0]);
      void'(bq.pop_front()); void'(fq.pop_front());
    end
    settle();
    n_cmp++; if (bus.dout !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL gaps_dout: got %h exp d4c3b2a1", bus.dout); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL gaps_vld_pulses: got %0d exp 1", vld_cnt - v0); end
    n_cmp++; if (serr_cnt - s0 !== 0) begin n_bad++; $display("FAIL gaps_sync_err: got %0d exp 0", serr_cnt - s0); end
  endtask

  task automatic test_resync();
    int v0 = vld_cnt, s0 = serr_cnt;
    logic [N*W-1:0] fb = rand_frame();
    build_frame(rand_frame(), 1'b1, '0);
    while (bq.size() > 13) begin void'(bq.pop_back()); void'(fq.pop_back()); end
    build_frame(fb, 1'b1, '0);
    send_q(10);
    settle();
    n_cmp++; if (serr_cnt - s0 !== 1) begin n_bad++; $display("FAIL resync_sync_err: got %0d exp 1", serr_cnt - s0); end
    n_cmp++; if (serr_cnt !== m_serr) begin n_bad++; $display("FAIL resync_serr_model: got %0d exp %0d", serr_cnt, m_serr); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL resync_vld_pulses: got %0d exp 1", vld_cnt - v0); end
    n_cmp++; if (bus.dout !== fb) begin n_bad++; $display("FAIL resync_dout: got %h exp %h", bus.dout, fb); end
    n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL resync_locked: got %b exp 1", bus.locked); end
  endtask

  task automatic test_nofsync();
    int v0 = vld_cnt, s0 = serr_cnt;
    logic [N*W-1:0] fc = rand_frame();
    build_frame(fc, 1'b1, '0);
    build_frame(rand_frame(), 1'b0, '0);
    send_q(10);
    settle();
    n_cmp++; if (serr_cnt - s0 !== 1) begin n_bad++; $display("FAIL nofsync_sync_err: got %0d exp 1", serr_cnt - s0); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL nofsync_locked: got %b exp 0", bus.locked); end
    n_cmp++; if (bus.ch_o !== '0) begin n_bad++; $display("FAIL nofsync_ch_o: got %0d exp 0", bus.ch_o); end
    n_cmp++; if (bus.dout !== fc) begin n_bad++; $display("FAIL nofsync_dout: got %h exp %h", bus.dout, fc); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL nofsync_vld_pulses: got %0d exp 1", vld_cnt - v0); end
  endtask

  task automatic test_rst_mid();
    int v0;
    logic [N*W-1:0] fe = rand_frame();
    build_frame(rand_frame(), 1'b1, '0);
    while (bq.size() > 20) begin void'(bq.pop_back()); void'(fq.pop_back()); end
    send_q(0);
    v0 = vld_cnt;
    @(negedge clk);
    rst = 1'b1; bus.din_vld = 1'b1; bus.fsync = 1'b1; bus.din = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    n_cmp++; if (bus.dout !== '0) begin n_bad++; $display("FAIL rstmid_dout: got %h exp 0", bus.dout); end
    n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rstmid_locked: got %b exp 0", bus.locked); end
    n_cmp++; if (bus.ch_o !== '0) begin n_bad++; $display("FAIL rstmid_ch_o: got %0d exp 0", bus.ch_o); end
    n_cmp++; if (bus.par_err !== '0) begin n_bad++; $display("FAIL rstmid_par_err: got %b exp 0", bus.par_err); end
    rst = 1'b0; bus.din_vld = 1'b0; bus.fsync = 1'b0;
    settle();
    n_cmp++; if (vld_cnt - v0 !== 0) begin n_bad++; $display("FAIL rstmid_vld_pulses: got %0d exp 0", vld_cnt - v0); end
    build_frame(fe, 1'b1, '0);
    send_q(20);
    settle();
    n_cmp++; if (bus.dout !== fe) begin n_bad++; $display("FAIL rstmid_next_dout: got %h exp %h", bus.dout, fe); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_bad++; $display("FAIL rstmid_next_vld: got %0d exp 1", vld_cnt - v0); end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    logic [N*W-1:0] fp = rand_frame();
    build_frame(fp, 1'b1, 4'b0100);
    send_q(20);
    settle();
    n_cmp++; if (bus.par_err !== 4'b0100) begin n_bad++; $display("FAIL parity_flag: got %b exp 0100", bus.par_err); end
    n_cmp++; if (bus.par_err !== m_perr) begin n_bad++; $display("FAIL parity_model: got %b exp %b", bus.par_err, m_perr); end
    n_cmp++; if (bus.dout !== fp) begin n_bad++; $display("FAIL parity_dout: got %h exp %h", bus.dout, fp); end
    build_frame(rand_frame(), 1'b1, '0);
    send_q(0);
    settle();
    n_cmp++; if (bus.par_err !== '0) begin n_bad++; $display("FAIL parity_clear: got %b exp 0", bus.par_err); end
  endtask
`endif

  task automatic test_back_to_back();
    int s0 = serr_cnt;
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 6; f++) build_frame(rand_frame(), 1'b1, PAR ? N'($urandom) : '0);
    send_q(20);
    settle();
    n_cmp++; if (got_q.size() !== 6) begin n_bad++; $display("FAIL b2b_count: got %0d exp 6", got_q.size()); end
    for (int f = 0; f < 6 && f < got_q.size() && f < exp_q.size(); f++) begin
      n_cmp++;
      if (got_q[f] !== exp_q[f]) begin n_bad++; $display("FAIL b2b_frame%0d: got %h exp %h", f, got_q[f], exp_q[f]); end
    end
    n_cmp++; if (bus.par_err !== (PAR ? m_perr : N'(0))) begin n_bad++; $display("FAIL b2b_par_err: got %b exp %b", bus.par_err, m_perr); end
    n_cmp++; if (serr_cnt - s0 !== 0) begin n_bad++; $display("FAIL b2b_sync_err: got %0d exp 0", serr_cnt - s0); end
  endtask

  initial begin
    bus.din = 1'b0; bus.din_vld = 1'b0; bus.fsync = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_gaps();
    test_resync();
    test_nofsync();
    test_rst_mid();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter N, default 4: number of TDM channels (slots per frame), N >= 2.
REQ-002 SHALL have parameter W, default 8: data bits per slot, W >= 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-004 SHALL have port rst  input  1  reset rst, synchronous, active-high.
REQ-005 SHALL have port din  input  1  serial TDM bit, MSB of each slot first.
REQ-006 SHALL have port din_vld  input  1  din qualifier; bits with din_vld=0 are ignored and leave all state unchanged.
REQ-007 SHALL have port fsync  input  1  frame marker, sampled only with din_vld=1; marks bit W-1 of channel 0.
REQ-008 SHALL have port dout  output  N*W  frame buffer; channel k occupies bits [k*W +: W].
REQ-009 SHALL have port dout_vld  output  1  one-cycle pulse when dout is updated.
REQ-010 SHALL have port ch_o  output  $clog2(N)  channel currently being received.
REQ-011 SHALL have port locked  output  1  high while in RUN.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse on a framing error.
REQ-013 SHALL have port par_err  output  N  per-channel parity error flags, updated together with dout.

Function
REQ-014 SHALL implement the states HUNT and RUN.
REQ-015 In HUNT, qualified bits without fsync SHALL be discarded; a qualified bit with fsync SHALL enter RUN and be stored as bit W-1 of channel 0 (bit_cnt=1, ch=0).
REQ-016 In RUN, each qualified bit SHALL shift into the working slot register; bit_cnt counts 0..S-1, where S is the slot length (W, or W+1 with parity).
REQ-017 At slot end, the data bits SHALL be written into the working frame at channel ch, and ch SHALL wrap from N-1 to 0.
REQ-018 On the last bit of channel N-1, the whole working frame SHALL be copied to dout on the same edge, and dout_vld SHALL pulse in the next cycle.
REQ-019 dout SHALL hold until the next complete frame, and partial frames SHALL never reach dout.
REQ-020 In RUN, the first qualified bit of a frame SHALL carry fsync; if it lacks fsync, sync_err SHALL pulse, the bit SHALL be discarded, and the state SHALL return to HUNT.
REQ-021 In RUN, fsync at any other bit position SHALL pulse sync_err, discard the partial frame, and restart at channel 0 with that bit as bit W-1 (state stays RUN).
REQ-022 ch_o SHALL equal the channel counter, and SHALL be 0 in HUNT.
REQ-023 Idle gaps (din_vld=0) of any length mid-slot SHALL be tolerated without error.

Reset
REQ-024 rst SHALL force HUNT, clear the counters, and clear the working frame.
REQ-025 rst SHALL set dout=0, dout_vld=0, ch_o=0, locked=0, sync_err=0 and par_err=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame with no dout_vld pulse.
REQ-027 rst SHALL take priority over all other inputs, including din_vld and fsync.

Configuration
REQ-028 Macro TDM_DEMUX_PARITY_EN defined: each slot SHALL carry an extra even-parity bit after its LSB (S=W+1).
REQ-029 With TDM_DEMUX_PARITY_EN defined, par_err[k] SHALL be set when channel k's received parity mismatches, and SHALL be loaded together with dout.
REQ-030 Macro TDM_DEMUX_PARITY_EN undefined: S SHALL be W and par_err SHALL be tied to 0.

Structure
REQ-031 Package tdm_pkg SHALL hold the state enum typedef (HUNT, RUN) and the parity slot-length helper constant/function.
REQ-032 A sub-module tdm_slot_sipo SHALL implement the slot shift register, bit counter, slot-done strobe and parity check.
REQ-033 tdm_demux SHALL instantiate tdm_slot_sipo once and own the FSM, channel counter and frame buffers.

Verification (N=4, W=8, parity off unless noted)
REQ-034 Scenario: fsync + 32 bits carrying 0xA1,0xB2,0xC3,0xD4 -> dout=0xD4C3B2A1, one dout_vld pulse, locked=1.
REQ-035 Scenario: bits sent with random din_vld gaps (density 30%) -> same dout, no sync_err.
REQ-036 Scenario: fsync reasserted at bit 13 -> sync_err pulse, no dout_vld; the following 32 bits give the correct frame.
REQ-037 Scenario: second frame sent without fsync -> sync_err pulse, locked=0, dout keeps the first frame.
REQ-038 Scenario: rst at bit 20 -> all outputs 0, HUNT; the next frame decodes correctly.
REQ-039 Scenario: TDM_DEMUX_PARITY_EN defined, parity of channel 2 flipped -> par_err=4'b0100 while dout is still loaded.
